// File: rtl/audio_frame_conditioner_if.sv
// Stereo sample / frame-request bundle between the Minimig audio source,
// the conditioner and the I2S transmitter side.
interface audio_frame_conditioner_if #(
  parameter int GAIN_W = 8,
  parameter int CNT_W  = 8
);
  logic              in_stb;
  logic [15:0]       in_left;
  logic [15:0]       in_right;
  logic [GAIN_W-1:0] gain;
  logic              mute;
  logic              frame_req;
  logic [15:0]       out_left;
  logic [15:0]       out_right;
  logic              out_fresh;
  logic [GAIN_W-1:0] cur_gain;
  logic [CNT_W-1:0]  underrun_cnt;
  logic [CNT_W-1:0]  overrun_cnt;

  modport master (
    output in_stb, in_left, in_right, gain, mute, frame_req,
    input  out_left, out_right, out_fresh, cur_gain, underrun_cnt, overrun_cnt
  );

  modport slave (
    input  in_stb, in_left, in_right, gain, mute, frame_req,
    output out_left, out_right, out_fresh, cur_gain, underrun_cnt, overrun_cnt
  );
endinterface

// File: rtl/audio_frame_conditioner.sv
// Gain/soft-mute conditioning of stereo samples with a one-deep pending
// buffer handed to the I2S transmitter on each frame request.
module audio_frame_conditioner #(
  parameter int GAIN_W   = 8,
  parameter int RAMP_DIV = 64,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  audio_frame_conditioner_if.slave bus
);
  localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int PROD_W = GAIN_W + 17;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32'sd32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32'sd32768);

  // Signed sample times unsigned gain, rescaled so 2^(GAIN_W-1) is unity.
  function automatic logic [15:0] scale_sat(input logic [15:0] sample,
                                            input logic [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shr;
    prod = PROD_W'($signed(sample)) * PROD_W'($signed({1'b0, g}));
    shr  = prod >>> (GAIN_W - 1);
    if (shr > SAT_MAX)      scale_sat = 16'h7FFF;
    else if (shr < SAT_MIN) scale_sat = 16'h8000;
    else                    scale_sat = shr[15:0];
  endfunction

  logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [15:0]       s1_left_q, s1_left_d, s1_right_q, s1_right_d;
  logic [GAIN_W-1:0] s1_gain_q, s1_gain_d;
  logic [15:0]       s2_left_q, s2_left_d, s2_right_q, s2_right_d;
  logic              pending_valid_q, pending_valid_d;
  logic [15:0]       pend_left_q, pend_left_d, pend_right_q, pend_right_d;
  logic [15:0]       out_left_q, out_left_d, out_right_q, out_right_d;
  logic              out_fresh_q, out_fresh_d;
  logic [GAIN_W-1:0] cur_gain_q, cur_gain_d, target_s;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  under_q, under_d, over_q, over_d;

  // Gain ramp plus the capture and multiply stages of the sample pipeline.
  always_comb begin
    target_s   = bus.mute ? {GAIN_W{1'b0}} : bus.gain;
    pre_d      = pre_q;
    cur_gain_d = cur_gain_q;
    s1_valid_d = bus.in_stb;
    s1_left_d  = s1_left_q;
    s1_right_d = s1_right_q;
    s1_gain_d  = s1_gain_q;
    s2_valid_d = s1_valid_q;
    s2_left_d  = s2_left_q;
    s2_right_d = s2_right_q;
    if (bus.in_stb) begin
      s1_left_d  = bus.in_left;
      s1_right_d = bus.in_right;
      s1_gain_d  = cur_gain_q;
      if (pre_q == PRE_W'(RAMP_DIV - 1)) begin
        pre_d = {PRE_W{1'b0}};
        if (cur_gain_q < target_s)      cur_gain_d = cur_gain_q + GAIN_W'(1);
        else if (cur_gain_q > target_s) cur_gain_d = cur_gain_q - GAIN_W'(1);
        else                            cur_gain_d = cur_gain_q;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end else begin
      pre_d = pre_q;
    end
    if (s1_valid_q) begin
      s2_left_d  = scale_sat(s1_left_q, s1_gain_q);
      s2_right_d = scale_sat(s1_right_q, s1_gain_q);
    end else begin
      s2_left_d  = s2_left_q;
      s2_right_d = s2_right_q;
    end
  end

  // Pending buffer, frame handoff and debug counters; a frame request reads
  // the old pending value before a same-cycle write replaces it.
  always_comb begin
    pending_valid_d = pending_valid_q;
    pend_left_d     = pend_left_q;
    pend_right_d    = pend_right_q;
    out_left_d      = out_left_q;
    out_right_d     = out_right_q;
    out_fresh_d     = out_fresh_q;
    under_d         = under_q;
    over_d          = over_q;
    if (bus.frame_req) begin
      if (pending_valid_q) begin
        out_left_d      = pend_left_q;
        out_right_d     = pend_right_q;
        out_fresh_d     = 1'b1;
        pending_valid_d = 1'b0;
      end else begin
        out_fresh_d = 1'b0;
        if (under_q != {CNT_W{1'b1}}) under_d = under_q + CNT_W'(1);
        else                          under_d = under_q;
      end
    end else begin
      out_fresh_d = out_fresh_q;
    end
    if (s2_valid_q) begin
      pend_left_d     = s2_left_q;
      pend_right_d    = s2_right_q;
      pending_valid_d = 1'b1;
      if (pending_valid_q && !bus.frame_req && (over_q != {CNT_W{1'b1}}))
        over_d = over_q + CNT_W'(1);
      else
        over_d = over_q;
    end else begin
      pend_left_d = pend_left_q;
    end
  end

  // State register for every flop in the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q      <= 1'b0;
      s1_left_q       <= 16'd0;
      s1_right_q      <= 16'd0;
      s1_gain_q       <= {GAIN_W{1'b0}};
      s2_valid_q      <= 1'b0;
      s2_left_q       <= 16'd0;
      s2_right_q      <= 16'd0;
      pending_valid_q <= 1'b0;
      pend_left_q     <= 16'd0;
      pend_right_q    <= 16'd0;
      out_left_q      <= 16'd0;
      out_right_q     <= 16'd0;
      out_fresh_q     <= 1'b0;
      cur_gain_q      <= {GAIN_W{1'b0}};
      pre_q           <= {PRE_W{1'b0}};
      under_q         <= {CNT_W{1'b0}};
      over_q          <= {CNT_W{1'b0}};
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_left_q       <= s1_left_d;
      s1_right_q      <= s1_right_d;
      s1_gain_q       <= s1_gain_d;
      s2_valid_q      <= s2_valid_d;
      s2_left_q       <= s2_left_d;
      s2_right_q      <= s2_right_d;
      pending_valid_q <= pending_valid_d;
      pend_left_q     <= pend_left_d;
      pend_right_q    <= pend_right_d;
      out_left_q      <= out_left_d;
      out_right_q     <= out_right_d;
      out_fresh_q     <= out_fresh_d;
      cur_gain_q      <= cur_gain_d;
      pre_q           <= pre_d;
      under_q         <= under_d;
      over_q          <= over_d;
    end
  end

  assign bus.out_left     = out_left_q;
  assign bus.out_right    = out_right_q;
  assign bus.out_fresh    = out_fresh_q;
  assign bus.cur_gain     = cur_gain_q;
  assign bus.underrun_cnt = under_q;
  assign bus.overrun_cnt  = over_q;
endmodule
